// File: rtl/wb_tlul_bridge_if.sv
// Bus bundle between the Caravel Wishbone slave pins and a TL-UL host port.
// The slave modport is the bridge view; the master modport is the view of
// whatever drives Wishbone and answers on TL-UL.
interface wb_tlul_bridge_if;
  // Wishbone slave side
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  // TL-UL A channel
  logic        tl_a_valid;
  logic        tl_a_ready;
  logic [2:0]  tl_a_opcode;
  logic [1:0]  tl_a_size;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_address;
  logic [31:0] tl_a_data;
  logic [7:0]  tl_a_source;
  // TL-UL D channel
  logic        tl_d_valid;
  logic        tl_d_ready;
  logic [31:0] tl_d_data;
  logic        tl_d_error;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output tl_a_valid, tl_a_opcode, tl_a_size, tl_a_mask, tl_a_address, tl_a_data, tl_a_source,
    input  tl_a_ready,
    input  tl_d_valid, tl_d_data, tl_d_error,
    output tl_d_ready
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  tl_a_valid, tl_a_opcode, tl_a_size, tl_a_mask, tl_a_address, tl_a_data, tl_a_source,
    output tl_a_ready,
    output tl_d_valid, tl_d_data, tl_d_error,
    input  tl_d_ready
  );
endinterface

// File: rtl/wb_tlul_bridge.sv
// Single-outstanding Wishbone classic slave to TL-UL host bridge.
// Every Wishbone cycle gets an ack: misses answer 0 immediately, and a
// silent TL target is cut off by a D-channel timeout that answers all-ones.
module wb_tlul_bridge #(
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_tlul_bridge_if.slave        bus,
  output logic                   timeout_o
);

  localparam logic [2:0]  OpPutFull    = 3'd0;
  localparam logic [2:0]  OpPutPartial = 3'd1;
  localparam logic [2:0]  OpGet        = 3'd4;
  localparam logic [15:0] CntLast      = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StAck} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic req, hit;
  assign req = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign hit = (bus.wbs_adr_i & ADDR_MASK) == ADDR_BASE;

  // Next-state: request latch, handshake tracking, response capture, timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            addr_d  = bus.wbs_adr_i & ~ADDR_MASK & 32'hFFFF_FFFC;
            wdata_d = bus.wbs_dat_i;
            we_d    = bus.wbs_we_i;
            if (!bus.wbs_we_i) begin
              opcode_d = OpGet;
              mask_d   = 4'hF;
            end else begin
              opcode_d = (bus.wbs_sel_i == 4'hF) ? OpPutFull : OpPutPartial;
              mask_d   = bus.wbs_sel_i;
            end
            state_d = StReq;
          end else begin
            // Outside the window: answer locally, nothing goes to the fabric.
            rdata_d = 32'h0;
            ack_d   = bus.wbs_cyc_i;
            state_d = StAck;
          end
        end
      end
      StReq: begin
        // No timeout here: TL-UL does not allow withdrawing a_valid.
        if (bus.tl_a_ready) begin
          cnt_d   = '0;
          state_d = StRsp;
        end
      end
      StRsp: begin
        // A response in the last counted cycle still beats the timeout.
        if (bus.tl_d_valid) begin
          rdata_d = we_q ? 32'h0 : (bus.tl_d_error ? 32'hFFFF_FFFF : bus.tl_d_data);
          ack_d   = bus.wbs_cyc_i;
          state_d = StAck;
        end else if (cnt_q == CntLast) begin
          rdata_d   = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          ack_d     = bus.wbs_cyc_i;
          state_d   = StAck;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      opcode_q  <= '0;
      mask_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus outputs; d_ready is also high in IDLE so late beats are drained.
  always_comb begin
    bus.wbs_ack_o    = ack_q;
    bus.wbs_dat_o    = rdata_q;
    bus.tl_a_valid   = (state_q == StReq);
    bus.tl_a_opcode  = opcode_q;
    bus.tl_a_size    = 2'd2;
    bus.tl_a_mask    = mask_q;
    bus.tl_a_address = addr_q;
    bus.tl_a_data    = wdata_q;
    bus.tl_a_source  = 8'd0;
    bus.tl_d_ready   = (state_q == StIdle) || (state_q == StRsp);
    timeout_o        = timeout_q;
  end

endmodule

// File: tb/tb_wb_tlul_bridge.sv
// Bench for wb_tlul_bridge: Wishbone master task, scripted TL-UL responder,
// and a negedge monitor that pops expected acks and A beats from queues.
`timescale 1ns/1ps
module tb_wb_tlul_bridge;
  localparam int unsigned TimeoutCycles = 8;

  logic clk;
  logic rst;
  logic timeout;

  int n_checks;
  int n_errors;
  int cyc_n;
  int a_beats;
  int d_beats;
  int ack_cnt;

  // Responder knobs, latched at each A handshake.
  int          a_stall_cfg;
  int          d_delay_cfg;
  logic        d_err_cfg;
  logic [31:0] d_data_cfg;

  typedef struct {
    logic [31:0] dat;
    logic        to;
    int          start;
    int          lat;
  } wb_exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_exp_t;

  wb_exp_t wb_q[$];
  a_exp_t  a_q[$];

  wb_tlul_bridge_if bus ();

  wb_tlul_bridge #(
    .ADDR_BASE      (32'h3000_0000),
    .ADDR_MASK      (32'hFF00_0000),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc_n = 0;
    forever begin
      @(posedge clk);
      cyc_n++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: ack scoreboard, A-beat scoreboard (every valid cycle, so stalls
  // also prove the fields are held), D-ready on every D beat.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wbs_ack_o) begin
          ack_cnt++;
          if (wb_q.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            e = wb_q.pop_front();
            check("ack_dat", bus.wbs_dat_o, e.dat);
            check("ack_cycle", cyc_n - e.start, e.lat);
            check("ack_timeout", timeout, e.to);
          end
        end else if (timeout) begin
          check("stray_timeout", 1, 0);
        end
        if (bus.tl_a_valid) begin
          if (a_q.size() == 0) begin
            check("unexpected_a", 1, 0);
          end else begin
            check("a_fields", {bus.tl_a_opcode, bus.tl_a_address, bus.tl_a_mask, bus.tl_a_data},
                  a_q[0]);
            check("a_size_src", {bus.tl_a_size, bus.tl_a_source}, {2'd2, 8'd0});
            if (bus.tl_a_ready) begin
              void'(a_q.pop_front());
              a_beats++;
            end
          end
        end
        if (bus.tl_d_valid) begin
          check("d_ready", bus.tl_d_ready, 1);
          d_beats++;
        end
      end
    end
  end

  // TL-UL responder: a_ready after a_stall_cfg valid cycles; one D beat
  // d_delay_cfg cycles after the cycle following the A handshake.
  initial begin
    int          a_cnt;
    int          d_wait;
    logic        hs;
    logic [31:0] p_data;
    logic        p_err;
    a_cnt  = 0;
    d_wait = -1;
    hs     = 1'b0;
    p_data = '0;
    p_err  = 1'b0;
    bus.tl_a_ready = 1'b0;
    bus.tl_d_valid = 1'b0;
    bus.tl_d_data  = '0;
    bus.tl_d_error = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.tl_a_valid && bus.tl_a_ready && !rst;
      @(posedge clk);
      #1;
      bus.tl_d_valid = 1'b0;
      bus.tl_d_error = 1'b0;
      if (hs) begin
        d_wait = d_delay_cfg;
        p_data = d_data_cfg;
        p_err  = d_err_cfg;
      end
      if (d_wait == 0) begin
        bus.tl_d_valid = 1'b1;
        bus.tl_d_data  = p_data;
        bus.tl_d_error = p_err;
        d_wait = -1;
      end else if (d_wait > 0) begin
        d_wait--;
      end
      if (bus.tl_a_valid) begin
        bus.tl_a_ready = (a_cnt >= a_stall_cfg);
        a_cnt++;
      end else begin
        bus.tl_a_ready = 1'b0;
        a_cnt = 0;
      end
    end
  end

  task automatic cfg(input int stall, input int delay, input logic err, input logic [31:0] data);
    a_stall_cfg = stall;
    d_delay_cfg = delay;
    d_err_cfg   = err;
    d_data_cfg  = data;
  endtask

  // One Wishbone cycle; lat is the ack cycle counted from the sampling edge.
  task automatic wb_txn(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                        input logic [3:0] sel, input logic hit, input logic [2:0] a_op,
                        input logic [31:0] a_addr, input logic [3:0] a_mask,
                        input logic [31:0] exp_dat, input logic exp_to, input int lat);
    wb_exp_t e;
    a_exp_t  a;
    int      n;
    @(posedge clk);
    #1;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    e.dat = exp_dat;
    e.to = exp_to;
    e.start = cyc_n;
    e.lat = lat;
    wb_q.push_back(e);
    if (hit) begin
      a.op = a_op;
      a.addr = a_addr;
      a.mask = a_mask;
      a.data = wdat;
      a_q.push_back(a);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbs_ack_o && n < 200);
    if (!bus.wbs_ack_o) begin
      check("ack_wait", 0, 1);
      wb_q.delete();
      a_q.delete();
    end
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_exp_t a;
    int     d_before;
    int     a_before;
    int     ack_before;
    n_checks = 0;
    n_errors = 0;
    a_beats  = 0;
    d_beats  = 0;
    ack_cnt  = 0;
    cfg(0, 0, 1'b0, 32'h0);
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", bus.wbs_ack_o, 0);
    check("rst_dat", bus.wbs_dat_o, 0);
    check("rst_a_valid", bus.tl_a_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_a_fields", {bus.tl_a_opcode, bus.tl_a_address, bus.tl_a_mask, bus.tl_a_data}, 0);
    check("rst_d_ready", bus.tl_d_ready, 1);

    // Full-word write, A accepted at once, D next cycle.
    cfg(0, 0, 1'b0, 32'h9999_9999);
    wb_txn(32'h3000_0010, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b1, 3'd0, 32'h10, 4'hF, 32'h0, 1'b0, 3);
    // Read with a 5-cycle A stall.
    cfg(5, 0, 1'b0, 32'h1234_5678);
    wb_txn(32'h3000_0100, 32'h0BAD_0BAD, 1'b0, 4'hF, 1'b1, 3'd4, 32'h100, 4'hF,
           32'h1234_5678, 1'b0, 8);
    // Partial write.
    cfg(0, 0, 1'b0, 32'h0);
    wb_txn(32'h3000_0204, 32'h00AB_0000, 1'b1, 4'b0100, 1'b1, 3'd1, 32'h204, 4'b0100,
           32'h0, 1'b0, 3);
    // Read with D error, D two cycles late.
    cfg(0, 2, 1'b1, 32'h1111_1111);
    wb_txn(32'h3000_0008, 32'h0, 1'b0, 4'h3, 1'b1, 3'd4, 32'h8, 4'hF,
           32'hFFFF_FFFF, 1'b0, 5);
    // Window miss.
    a_before = a_beats;
    wb_txn(32'h4000_0000, 32'h0, 1'b0, 4'hF, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    check("miss_no_a", a_beats - a_before, 0);

    // Timeout, then a late D beat three cycles after the ack.
    d_before = d_beats;
    cfg(0, TimeoutCycles + 3, 1'b0, 32'hDEAD_BEEF);
    wb_txn(32'h3000_0020, 32'h0, 1'b0, 4'hF, 1'b1, 3'd4, 32'h20, 4'hF,
           32'hFFFF_FFFF, 1'b1, TimeoutCycles + 2);
    check("to_no_d_yet", d_beats - d_before, 0);
    repeat (4) @(negedge clk);
    check("late_d_consumed", d_beats - d_before, 1);
    check("late_d_ignored", bus.wbs_dat_o, 32'hFFFF_FFFF);
    cfg(0, 0, 1'b0, 32'h55AA_1234);
    wb_txn(32'h3000_0ABE, 32'h0, 1'b0, 4'hF, 1'b1, 3'd4, 32'hABC, 4'hF,
           32'h55AA_1234, 1'b0, 3);

    // D arrives in the same cycle the timeout would fire: response wins.
    cfg(0, TimeoutCycles - 1, 1'b0, 32'h0F0F_0F0F);
    wb_txn(32'h3000_0030, 32'h0, 1'b0, 4'hF, 1'b1, 3'd4, 32'h30, 4'hF,
           32'h0F0F_0F0F, 1'b0, TimeoutCycles + 2);

    // Reset while stalled in REQ.
    ack_before = ack_cnt;
    cfg(1000, 0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    bus.wbs_adr_i = 32'h3000_0050;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    a.op = 3'd4;
    a.addr = 32'h50;
    a.mask = 4'hF;
    a.data = 32'h0;
    a_q.push_back(a);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_a_valid", bus.tl_a_valid, 1);
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_q.delete();
    cfg(0, 0, 1'b0, 32'h0);
    check("mid_rst_a_valid", bus.tl_a_valid, 0);
    check("mid_rst_ack", bus.wbs_ack_o, 0);
    check("mid_rst_dat", bus.wbs_dat_o, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_a_fields", {bus.tl_a_opcode, bus.tl_a_address, bus.tl_a_mask, bus.tl_a_data},
          0);
    check("mid_rst_d_ready", bus.tl_d_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_ack", ack_cnt - ack_before, 0);

    // Cyc dropped while waiting in RSP: TL side completes, no ack.
    ack_before = ack_cnt;
    d_before = d_beats;
    a_before = a_beats;
    cfg(0, 4, 1'b0, 32'h7777_0000);
    @(posedge clk);
    #1;
    bus.wbs_adr_i = 32'h3000_0040;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    a.op = 3'd4;
    a.addr = 32'h40;
    a.mask = 4'hF;
    a.data = 32'h0;
    a_q.push_back(a);
    repeat (2) @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("drop_a_done", a_beats - a_before, 1);
    check("drop_d_done", d_beats - d_before, 1);
    check("drop_no_ack", ack_cnt - ack_before, 0);
    cfg(0, 0, 1'b0, 32'h0);
    wb_txn(32'h3000_0044, 32'h0000_BEEF, 1'b1, 4'b0011, 1'b1, 3'd1, 32'h44, 4'b0011,
           32'h0, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    check("total_a_beats", a_beats, 9);
    check("wb_q_empty", wb_q.size(), 0);
    check("a_q_empty", a_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
